// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receive path: byte width, default
// buffer depth and the byte type.
package rs232_pkg;
  localparam int RS232_BYTE_W        = 8;
  localparam int RS232_DEFAULT_DEPTH = 16;

  typedef logic [RS232_BYTE_W-1:0] byte_t;
endpackage

// File: rtl/rs232_rx_fifo_if.sv
// Receiver-to-consumer handshake bundle for the RS-232 receive FIFO.
// The producer/consumer side uses master; the FIFO uses slave.
interface rs232_rx_fifo_if;
  import rs232_pkg::*;

  byte_t rx_data;
  logic  rx_vld;
  byte_t out_data;
  logic  out_valid;
  logic  out_ready;
  logic  full;
  logic  empty;
  logic  overrun;
  logic  overrun_clr;

  modport master (
    output rx_data, rx_vld, out_ready, overrun_clr,
    input  out_data, out_valid, full, empty, overrun
  );

  modport slave (
    input  rx_data, rx_vld, out_ready, overrun_clr,
    output out_data, out_valid, full, empty, overrun
  );
endinterface

// File: rtl/rs232_fifo_mem.sv
// DEPTH x byte storage: synchronous write, asynchronous read, no control.
module rs232_fifo_mem
  import rs232_pkg::*;
#(
  parameter int DEPTH = RS232_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);
  byte_t mem_r [DEPTH];

  // Write port: one byte per cycle when enabled.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];
endmodule

// File: rtl/rs232_rx_fifo.sv
// First-word-fall-through byte FIFO behind the RS-232 receiver, with a
// sticky overrun flag. Optional level/almost_full outputs: RS232_RX_FIFO_LEVEL_EN.
module rs232_rx_fifo
  import rs232_pkg::*;
#(
  parameter int DEPTH = RS232_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
`ifdef RS232_RX_FIFO_LEVEL_EN
  , parameter int AFULL_THRESH = DEPTH - 2
`endif
) (
  input  logic          clock,
  input  logic          reset,
  rs232_rx_fifo_if.slave bus
`ifdef RS232_RX_FIFO_LEVEL_EN
  , output logic [AW:0] level
  , output logic        almost_full
`endif
);
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          overrun_r;
  logic          full_s;
  logic          empty_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  byte_t         rd_data_s;

  // Handshake decode; a pop frees the slot a same-cycle push into a full queue needs.
  always_comb begin
    full_s  = (count_r == (AW+1)'(DEPTH));
    empty_s = (count_r == {(AW+1){1'b0}});
    pop_s   = !empty_s && bus.out_ready;
    push_s  = bus.rx_vld && (!full_s || pop_s);
    drop_s  = bus.rx_vld && full_s && !pop_s;
  end

  // Pointer, occupancy and sticky overrun registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= {(AW+1){1'b0}};
      overrun_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (bus.overrun_clr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  rs232_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (bus.rx_data),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  assign bus.out_data  = empty_s ? {RS232_BYTE_W{1'b0}} : rd_data_s;
  assign bus.out_valid = !empty_s;
  assign bus.full      = full_s;
  assign bus.empty     = empty_s;
  assign bus.overrun   = overrun_r;

`ifdef RS232_RX_FIFO_LEVEL_EN
  assign level       = count_r;
  assign almost_full = (count_r >= (AW+1)'(AFULL_THRESH));
`endif
endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Self-checking bench for rs232_rx_fifo: directed steps plus randomized
// interleaving, checked against a queue-based reference model.
module tb_rs232_rx_fifo;
  import rs232_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clock = 1'b0;
  logic reset;
  rs232_rx_fifo_if bus ();
`ifdef RS232_RX_FIFO_LEVEL_EN
  logic [AW:0] level;
  logic        almost_full;
`endif

  rs232_rx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef RS232_RX_FIFO_LEVEL_EN
    , .level       (level)
    , .almost_full (almost_full)
`endif
  );

  always #5 clock = ~clock;

  int    checks   = 0;
  int    failures = 0;
  byte_t model_q[$];
  bit    model_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [7:0] exp_data;
    exp_data = (model_q.size() > 0) ? model_q[0] : 8'h00;
    chk({tag, "_valid"},   32'(bus.out_valid), 32'(model_q.size() > 0));
    chk({tag, "_empty"},   32'(bus.empty),     32'(model_q.size() == 0));
    chk({tag, "_full"},    32'(bus.full),      32'(model_q.size() == DEPTH));
    chk({tag, "_overrun"}, 32'(bus.overrun),   32'(model_ovr));
    chk({tag, "_data"},    32'(bus.out_data),  32'(exp_data));
`ifdef RS232_RX_FIFO_LEVEL_EN
    chk({tag, "_level"},   32'(level),         32'(model_q.size()));
    chk({tag, "_afull"},   32'(almost_full),   32'(model_q.size() >= DEPTH - 2));
`endif
  endtask

  // One clock: drive inputs, advance the model, then sample 1 ns after the edge.
  task automatic step(input bit rst, input bit vld, input byte_t d,
                      input bit rdy, input bit clr, input string tag);
    bit pop;
    bit drop;
    byte_t tmp;
    reset           = rst;
    bus.rx_vld      = vld;
    bus.rx_data     = d;
    bus.out_ready   = rdy;
    bus.overrun_clr = clr;
    if (rst) begin
      model_q.delete();
      model_ovr = 1'b0;
    end else begin
      pop  = (model_q.size() > 0) && rdy;
      drop = vld && (model_q.size() == DEPTH) && !pop;
      if (pop) tmp = model_q.pop_front();
      if (vld && !drop) model_q.push_back(d);
      if (drop) model_ovr = 1'b1;
      else if (clr) model_ovr = 1'b0;
    end
    @(posedge clock);
    #1;
    compare_all(tag);
  endtask

  initial begin
    byte_t last_seen;
    int    k;
    bit    vld;
    bit    rdy;

    // Reset state
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "reset0");
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "reset1");
    chk("reset_empty", 32'(bus.empty), 32'd1);

    // Single byte latency, then pop
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, "single_push");
    chk("single_data", 32'(bus.out_data), 32'h0000_00A5);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "single_pop");
    chk("single_empty", 32'(bus.empty), 32'd1);

    // out_ready while empty is ignored
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "empty_ready");

    // Fill 0x00..0x0F, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, "fill");
    chk("fill_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(bus.out_data), 32'(i));
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "drain");
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Overrun: drop while full, set-wins-over-clear, then clear alone
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 8'h54)), 1'b0, 1'b0, "refill");
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, "ovr_drop");
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    step(1'b0, 1'b1, 8'h56, 1'b0, 1'b1, "ovr_set_wins");
    chk("ovr_held", 32'(bus.overrun), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "ovr_clear");
    chk("ovr_cleared", 32'(bus.overrun), 32'd0);

    // Push into a full queue with a simultaneous pop
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, "full_pushpop");
    chk("pushpop_full", 32'(bus.full), 32'd1);
    last_seen = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      chk("no_dropped_byte", 32'(bus.out_data == 8'h55 || bus.out_data == 8'h56), 32'd0);
      last_seen = bus.out_data;
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "drain2");
    end
    chk("pushpop_last", 32'(last_seen), 32'h0000_0077);

    // Wrap-around: 40 bytes 0x10..0x37 with random gaps on both sides
    k = 0;
    begin
      int idx = 0;
      for (int c = 0; c < 2000 && (idx < 40 || model_q.size() > 0); c++) begin
        vld = (idx < 40) && ($urandom_range(0, 2) != 0);
        rdy = ($urandom_range(0, 2) != 0);
        if (vld && model_q.size() == DEPTH && !rdy) vld = 1'b0;
        if (rdy && model_q.size() > 0) begin
          chk("wrap_order", 32'(bus.out_data), 32'(8'h10 + k));
          k++;
        end
        step(1'b0, vld, 8'(8'h10 + idx), rdy, 1'b0, "wrap");
        if (vld) idx++;
      end
      chk("wrap_pushed", 32'(idx), 32'd40);
    end
    chk("wrap_popped", 32'(k), 32'd40);

    // Reset with bytes queued and a push in the reset cycle
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "pre_reset");
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, "pre_reset_ovr_none");
    step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, "mid_reset");
    chk("mid_reset_empty", 32'(bus.empty), 32'd1);
    chk("mid_reset_ovr", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
